abus_initiator: RTL and testbench
=================================

# abus_initiator

Synthesizable A-bus initiator that issues single Saturn cartridge-bus read and write cycles on the A-bus pins, toward the wasca A-bus slave. It is the master end of the same multiplexed address/data protocol. A simple valid/ready command port drives it, either from a Nios-side test register block or a bench sequencer. It sits in the board loopback and self-test build, driving a second A-bus header or wired directly to the slave's pins.

## Interface
Parameters:
- SETUP_CYCLES, 2: cycles the address phase is driven, CS low, before the strobe.
- STROBE_CYCLES, 6: minimum RD/WR strobe width in cycles.
- HOLD_CYCLES, 2: cycles CS and write data are held after the strobe rises.
- TIMEOUT_CYCLES, 1023: maximum strobe length while WAIT is asserted, before abort (10-bit counter).

Ports:
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_cs  in  2  chip select index 0..2; 3 is invalid.
- cmd_addr  in  26  [25:16] go to abus_address, [15:0] to the address phase of abus_ad_out.
- cmd_be  in  2  byte enables; [1] is the upper byte.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data; 0 for writes and errors.
- rsp_error  out  1  qualified by rsp_valid: invalid cs or timeout.
- abus_address  out  10  upper address.
- abus_chipselect  out  3  active-low CS0..CS2.
- abus_read  out  1  active-low RD.
- abus_write  out  2  active-low byte write strobes.
- abus_ad_out / abus_ad_oe / abus_ad_in  out / out / in  16 / 1 / 16  split tri-state for abus_addressdata.
- abus_waitrequest  in  1  A-bus WAIT, active-low (0 = extend), asynchronous.
- abus_interrupt  in  1  asynchronous slave interrupt.
- irq  out  1  abus_interrupt after the 2-flop synchronizer.

## Operation
- States are IDLE, ADDR, STROBE, HOLD and DONE.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, abus_chipselect=3'b111, abus_read=1, abus_write=2'b11, abus_ad_oe=0, abus_ad_out=0, abus_address=0, irq=0, synchronizers=idle (WAIT synced to 1). cmd_ready goes to 1 on the first cycle after reset deasserts.
- cmd_ready=1 only in IDLE. A command is accepted on the edge where cmd_valid and cmd_ready are both 1, and all command fields are registered then.
- Immediate completion: cmd_cs=3, or a write with cmd_be=00, goes straight to DONE with no pin activity. rsp_error=1 for cs=3 and 0 for be=00.
- ADDR, SETUP_CYCLES cycles:
  - CS[cmd_cs] low, abus_address and abus_ad_out = address, abus_ad_oe=1.
- STROBE:
  - Read: abus_ad_oe=0, RD low.
  - Write: abus_ad_out=wdata, abus_ad_oe=1, abus_write[i] low where be[i]=1.
  - Exit at the first cycle where the strobe count is >= STROBE_CYCLES and synced WAIT=1.
  - Read data is captured from abus_ad_in on that exit edge.
  - If the count reaches TIMEOUT_CYCLES: abort, rdata=0, error flag set.
- HOLD, HOLD_CYCLES cycles: strobes high, CS low, write data and oe still driven.
- DONE, 1 cycle: CS high, oe=0, rsp_valid=1 with rdata and error. Next state is IDLE.
- Reset mid-cycle: all pins return to idle values on that edge, no rsp_valid is issued, and the command is dropped.
- A new command cannot be accepted in the same cycle as DONE.

## Timing
- Accept at edge 0. ADDR occupies cycles 1..S, STROBE S+1..S+T+W, HOLD through S+T+W+H, rsp_valid at S+T+W+H+1. W = wait-extension cycles; defaults with W=0 give 11.
- WAIT and interrupt pass through a 2-flop synchronizer (2-cycle lag). A slave must assert WAIT at least 2 cycles before STROBE_CYCLES elapses to extend the strobe.
- Back-to-back throughput is one command per S+T+W+H+2 cycles.

## Structure
- Package abus_pkg holds:
  - the state enum;
  - CS index constants;
  - idle pin levels (CS_IDLE=3'b111, WR_IDLE=2'b11);
  - CS_INVALID=2'd3.
- Sub-module abus_sync2 is a parameterized-width 2-flop synchronizer, instantiated for WAIT and interrupt.
- A single down-counter serves the setup, strobe, hold and timeout phases.

## Test plan
- Read, cs=1, addr=26'h012_3456, slave returns 16'hBEEF with no wait:
  - CS1 low, abus_address=10'h012, ad_out=16'h3456 for 2 cycles, RD low 6 cycles;
  - rsp_valid at cycle 11, rdata=BEEF, error=0.
- Write, cs=0, be=10, wdata=16'hA55A: WR[1] low, WR[0] high for 6 cycles, data held through HOLD, rsp_valid at 11.
- WAIT held low for 10 extra cycles: strobe lengthens accordingly, rsp_valid at cycle 21 with correct data.
- WAIT stuck low: strobe aborts after 1023 cycles, rsp_error=1, rdata=0, CS released.
- cs=3, and separately a write with be=00: no pin toggles, rsp_valid 2 cycles after accept; error=1 and 0 respectively.
- reset asserted mid-STROBE: the next edge gives all-idle pins, rsp_valid=0, and cmd_ready=1 one cycle after reset drops.

Source files
------------

// File: rtl/abus_pkg.sv
// Shared types and constants for the A-bus initiator: FSM state encoding,
// chip-select indices, idle pin levels and the chip-select decoder.
package abus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } abus_state_e;

  localparam logic [1:0] CS_IDX0    = 2'd0;
  localparam logic [1:0] CS_IDX1    = 2'd1;
  localparam logic [1:0] CS_IDX2    = 2'd2;
  localparam logic [1:0] CS_INVALID = 2'd3;

  localparam logic [2:0] CS_IDLE = 3'b111;
  localparam logic [1:0] WR_IDLE = 2'b11;

  // Active-low chip-select pattern for an index; the invalid index selects nothing.
  function automatic logic [2:0] cs_decode_n(input logic [1:0] idx);
    logic [2:0] cs_n;
    case (idx)
      CS_IDX0: cs_n = 3'b110;
      CS_IDX1: cs_n = 3'b101;
      CS_IDX2: cs_n = 3'b011;
      default: cs_n = CS_IDLE;
    endcase
    return cs_n;
  endfunction

endpackage

// File: rtl/abus_sync2.sv
// Two-flop synchronizer for asynchronous A-bus inputs (WAIT, interrupt).
// RESET_VAL lets each instance come out of reset at its inactive level.
module abus_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  // Next values of the two synchronizer stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/abus_initiator.sv
// A-bus initiator: turns one valid/ready command into a single Saturn
// cartridge-bus read or write cycle (ADDR -> STROBE -> HOLD -> DONE).
// All pin and response outputs are registered and computed from the next state,
// so they change on the same edge as the FSM.
module abus_initiator
  import abus_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int STROBE_CYCLES  = 6,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_cs,
  input  logic [25:0] cmd_addr,
  input  logic [1:0]  cmd_be,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic [9:0]  abus_address,
  output logic [2:0]  abus_chipselect,
  output logic        abus_read,
  output logic [1:0]  abus_write,
  output logic [15:0] abus_ad_out,
  output logic        abus_ad_oe,
  input  logic [15:0] abus_ad_in,
  input  logic        abus_waitrequest,
  input  logic        abus_interrupt,
  output logic        irq
);

  // Counter reload values: each phase loads (length - 1) and ends at zero.
  // The strobe phase loads the timeout length; elapsed strobe cycles are
  // TIMEOUT_CYCLES - cnt, so the minimum width is met once cnt <= STROBE_DONE.
  localparam logic [9:0] SETUP_LD    = 10'(SETUP_CYCLES - 1);
  localparam logic [9:0] HOLD_LD     = 10'(HOLD_CYCLES - 1);
  localparam logic [9:0] TMO_LD      = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] STROBE_DONE = 10'(TIMEOUT_CYCLES - STROBE_CYCLES);

  abus_state_e state_d, state_q;
  logic [9:0]  cnt_d, cnt_q;
  logic        write_d, write_q;
  logic [1:0]  cs_d, cs_q;
  logic [25:0] addr_d, addr_q;
  logic [1:0]  be_d, be_q;
  logic [15:0] wdata_d, wdata_q;
  logic        bypass_d, bypass_q;
  logic        err_d, err_q;
  logic [15:0] rdat_d, rdat_q;

  logic        cmd_ready_d, cmd_ready_q;
  logic        rsp_valid_d, rsp_valid_q;
  logic [15:0] rsp_rdata_d, rsp_rdata_q;
  logic        rsp_error_d, rsp_error_q;
  logic [9:0]  address_d, address_q;
  logic [2:0]  cs_n_d, cs_n_q;
  logic        read_n_d, read_n_q;
  logic [1:0]  write_n_d, write_n_q;
  logic [15:0] ad_out_d, ad_out_q;
  logic        ad_oe_d, ad_oe_q;

  logic        accept;
  logic        wait_sync;
  logic        eff_bypass;
  logic [1:0]  eff_cs;
  logic [25:0] eff_addr;

  abus_sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_wait (
    .clk   (clk),
    .reset (reset),
    .d     (abus_waitrequest),
    .q     (wait_sync)
  );

  abus_sync2 #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_irq (
    .clk   (clk),
    .reset (reset),
    .d     (abus_interrupt),
    .q     (irq)
  );

  assign accept = cmd_valid & cmd_ready_q;

  // Next-state, shared down-counter, command capture and read-data capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    cs_d     = cs_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    bypass_d = bypass_q;
    err_d    = err_q;
    rdat_d   = rdat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d  = cmd_write;
          cs_d     = cmd_cs;
          addr_d   = cmd_addr;
          be_d     = cmd_be;
          wdata_d  = cmd_wdata;
          // Invalid CS, or a write with no byte lanes, completes without pin activity.
          bypass_d = (cmd_cs == CS_INVALID) || (cmd_write && (cmd_be == 2'b00));
          err_d    = (cmd_cs == CS_INVALID);
          rdat_d   = 16'h0000;
          cnt_d    = SETUP_LD;
          state_d  = ST_ADDR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bypass_q) begin
          // One decode cycle with pins idle, then respond.
          state_d = ST_DONE;
        end else if (cnt_q == 10'd0) begin
          cnt_d   = TMO_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d   = cnt_q - 10'd1;
        end
      end
      ST_STROBE: begin
        if ((cnt_q <= STROBE_DONE) && wait_sync) begin
          rdat_d  = write_q ? 16'h0000 : abus_ad_in;
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else if (cnt_q == 10'd0) begin
          // Slave held WAIT for the whole timeout window: abort the cycle.
          rdat_d  = 16'h0000;
          err_d   = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          cnt_d   = cnt_q - 10'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 10'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - 10'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command fields as seen on the accept edge (live inputs) or afterwards (captured).
  always_comb begin
    if (accept) begin
      eff_bypass = (cmd_cs == CS_INVALID) || (cmd_write && (cmd_be == 2'b00));
      eff_cs     = cmd_cs;
      eff_addr   = cmd_addr;
    end else begin
      eff_bypass = bypass_q;
      eff_cs     = cs_q;
      eff_addr   = addr_q;
    end
  end

  // Pin and response levels for the state being entered.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 16'h0000;
    rsp_error_d = 1'b0;
    address_d   = 10'h000;
    cs_n_d      = CS_IDLE;
    read_n_d    = 1'b1;
    write_n_d   = WR_IDLE;
    ad_out_d    = 16'h0000;
    ad_oe_d     = 1'b0;
    case (state_d)
      ST_ADDR: begin
        if (!eff_bypass) begin
          cs_n_d    = cs_decode_n(eff_cs);
          address_d = eff_addr[25:16];
          ad_out_d  = eff_addr[15:0];
          ad_oe_d   = 1'b1;
        end else begin
          cs_n_d    = CS_IDLE;
        end
      end
      ST_STROBE: begin
        cs_n_d    = cs_decode_n(cs_q);
        address_d = addr_q[25:16];
        if (write_q) begin
          ad_out_d  = wdata_q;
          ad_oe_d   = 1'b1;
          write_n_d = ~be_q;
        end else begin
          read_n_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        cs_n_d    = cs_decode_n(cs_q);
        address_d = addr_q[25:16];
        if (write_q) begin
          ad_out_d = wdata_q;
          ad_oe_d  = 1'b1;
        end else begin
          ad_oe_d  = 1'b0;
        end
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rdat_q;
        rsp_error_d = err_q;
      end
      default: begin
        cs_n_d = CS_IDLE;
      end
    endcase
  end

  // State, counter, captured command and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 10'd0;
      write_q     <= 1'b0;
      cs_q        <= 2'd0;
      addr_q      <= 26'd0;
      be_q        <= 2'b00;
      wdata_q     <= 16'h0000;
      bypass_q    <= 1'b0;
      err_q       <= 1'b0;
      rdat_q      <= 16'h0000;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_error_q <= 1'b0;
      address_q   <= 10'h000;
      cs_n_q      <= CS_IDLE;
      read_n_q    <= 1'b1;
      write_n_q   <= WR_IDLE;
      ad_out_q    <= 16'h0000;
      ad_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      bypass_q    <= bypass_d;
      err_q       <= err_d;
      rdat_q      <= rdat_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      address_q   <= address_d;
      cs_n_q      <= cs_n_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_error       = rsp_error_q;
  assign abus_address    = address_q;
  assign abus_chipselect = cs_n_q;
  assign abus_read       = read_n_q;
  assign abus_write      = write_n_q;
  assign abus_ad_out     = ad_out_q;
  assign abus_ad_oe      = ad_oe_q;

endmodule

// File: tb/tb_abus_initiator.sv
// Directed self-checking bench for abus_initiator with default parameters.
// Cycle k after an accept is the clock period following accept edge + (k-1).
module tb_abus_initiator;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_cs;
  logic [25:0] cmd_addr;
  logic [1:0]  cmd_be;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic [9:0]  abus_address;
  logic [2:0]  abus_chipselect;
  logic        abus_read;
  logic [1:0]  abus_write;
  logic [15:0] abus_ad_out;
  logic        abus_ad_oe;
  logic [15:0] abus_ad_in;
  logic        abus_waitrequest;
  logic        abus_interrupt;
  logic        irq;

  int n_assert;
  int n_fail;
  int cyc, rd_lo, wr1_lo, wr0_lo, cs_act, oe_cyc, dat_cyc;

  abus_initiator dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_cs           (cmd_cs),
    .cmd_addr         (cmd_addr),
    .cmd_be           (cmd_be),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .abus_address     (abus_address),
    .abus_chipselect  (abus_chipselect),
    .abus_read        (abus_read),
    .abus_write       (abus_write),
    .abus_ad_out      (abus_ad_out),
    .abus_ad_oe       (abus_ad_oe),
    .abus_ad_in       (abus_ad_in),
    .abus_waitrequest (abus_waitrequest),
    .abus_interrupt   (abus_interrupt),
    .irq              (irq)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] cs, input logic [25:0] addr,
                       input logic [1:0] be, input logic [15:0] wd);
    chk("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_write = wr;
    cmd_cs    = cs;
    cmd_addr  = addr;
    cmd_be    = be;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // Walk from cycle 1 until rsp_valid (bounded), tallying pin activity.
  task automatic run_to_rsp(input int max_cyc, input int release_cyc, input logic [15:0] exp_dat);
    cyc = 1; rd_lo = 0; wr1_lo = 0; wr0_lo = 0; cs_act = 0; oe_cyc = 0; dat_cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (cyc == release_cyc) abus_waitrequest = 1'b1;
      if (abus_read == 1'b0) rd_lo++;
      if (abus_write[1] == 1'b0) wr1_lo++;
      if (abus_write[0] == 1'b0) wr0_lo++;
      if (abus_chipselect != 3'b111) cs_act++;
      if (abus_ad_oe == 1'b1) oe_cyc++;
      if ((abus_ad_oe == 1'b1) && (abus_ad_out == exp_dat)) dat_cyc++;
      if (rsp_valid == 1'b1) break;
      step();
      cyc++;
    end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_cs = 2'd0;
    cmd_addr = 26'd0; cmd_be = 2'b00; cmd_wdata = 16'h0000;
    abus_ad_in = 16'h0000; abus_waitrequest = 1'b1; abus_interrupt = 1'b0;
    step(); step(); step();

    // Reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_cs",        {29'd0, abus_chipselect}, 32'h7);
    chk("rst_rd",        {31'd0, abus_read}, 32'd1);
    chk("rst_wr",        {30'd0, abus_write}, 32'h3);
    chk("rst_oe",        {31'd0, abus_ad_oe}, 32'd0);
    chk("rst_ad_out",    {16'd0, abus_ad_out}, 32'd0);
    chk("rst_address",   {22'd0, abus_address}, 32'd0);
    chk("rst_irq",       {31'd0, irq}, 32'd0);
    reset = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Read cs=1, no wait
    abus_ad_in = 16'hBEEF;
    issue(1'b0, 2'd1, 26'h012_3456, 2'b11, 16'h0000);
    chk("t1_c1_cs",   {29'd0, abus_chipselect}, 32'h5);
    chk("t1_c1_addr", {22'd0, abus_address}, 32'h012);
    chk("t1_c1_ad",   {16'd0, abus_ad_out}, 32'h3456);
    chk("t1_c1_oe",   {31'd0, abus_ad_oe}, 32'd1);
    chk("t1_c1_rd",   {31'd0, abus_read}, 32'd1);
    run_to_rsp(40, 0, 16'h3456);
    chk("t1_rsp_cyc", cyc, 32'd11);
    chk("t1_rdata",   {16'd0, rsp_rdata}, 32'hBEEF);
    chk("t1_error",   {31'd0, rsp_error}, 32'd0);
    chk("t1_rd_lo",   rd_lo, 32'd6);
    chk("t1_wr_lo",   wr1_lo + wr0_lo, 32'd0);
    chk("t1_cs_act",  cs_act, 32'd10);
    chk("t1_addr_oe", dat_cyc, 32'd2);
    step();
    chk("t1_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("t1_rsp_pulse",   {31'd0, rsp_valid}, 32'd0);

    // Write cs=0, be=10
    issue(1'b1, 2'd0, 26'h000_0010, 2'b10, 16'hA55A);
    chk("t2_c1_cs", {29'd0, abus_chipselect}, 32'h6);
    run_to_rsp(40, 0, 16'hA55A);
    chk("t2_rsp_cyc", cyc, 32'd11);
    chk("t2_wr1_lo",  wr1_lo, 32'd6);
    chk("t2_wr0_lo",  wr0_lo, 32'd0);
    chk("t2_rd_lo",   rd_lo, 32'd0);
    chk("t2_data",    dat_cyc, 32'd8);
    chk("t2_oe",      oe_cyc, 32'd10);
    chk("t2_rdata",   {16'd0, rsp_rdata}, 32'd0);
    chk("t2_error",   {31'd0, rsp_error}, 32'd0);
    step();

    // Read cs=2 with 10 wait-extension cycles
    abus_ad_in = 16'h1234;
    abus_waitrequest = 1'b0;
    issue(1'b0, 2'd2, 26'h3FF_0001, 2'b11, 16'h0000);
    chk("t3_c1_cs",   {29'd0, abus_chipselect}, 32'h3);
    chk("t3_c1_addr", {22'd0, abus_address}, 32'h3FF);
    run_to_rsp(60, 16, 16'h0001);
    chk("t3_rsp_cyc", cyc, 32'd21);
    chk("t3_rd_lo",   rd_lo, 32'd16);
    chk("t3_rdata",   {16'd0, rsp_rdata}, 32'h1234);
    chk("t3_error",   {31'd0, rsp_error}, 32'd0);
    step();

    // WAIT stuck low: timeout abort
    abus_ad_in = 16'hFFFF;
    abus_waitrequest = 1'b0;
    issue(1'b0, 2'd0, 26'h001_0002, 2'b11, 16'h0000);
    run_to_rsp(1100, 0, 16'h0002);
    chk("t4_rsp_cyc", cyc, 32'd1028);
    chk("t4_rd_lo",   rd_lo, 32'd1023);
    chk("t4_error",   {31'd0, rsp_error}, 32'd1);
    chk("t4_rdata",   {16'd0, rsp_rdata}, 32'd0);
    chk("t4_cs_rel",  {29'd0, abus_chipselect}, 32'h7);
    abus_waitrequest = 1'b1;
    step();

    // Invalid chip select
    issue(1'b0, 2'd3, 26'h012_3456, 2'b11, 16'h0000);
    run_to_rsp(10, 0, 16'h3456);
    chk("t5_rsp_cyc", cyc, 32'd2);
    chk("t5_error",   {31'd0, rsp_error}, 32'd1);
    chk("t5_pins",    cs_act + rd_lo + oe_cyc + wr1_lo + wr0_lo, 32'd0);
    step();

    // Write with no byte enables
    issue(1'b1, 2'd1, 26'h012_3456, 2'b00, 16'h5555);
    run_to_rsp(10, 0, 16'h5555);
    chk("t6_rsp_cyc", cyc, 32'd2);
    chk("t6_error",   {31'd0, rsp_error}, 32'd0);
    chk("t6_pins",    cs_act + rd_lo + oe_cyc + wr1_lo + wr0_lo, 32'd0);
    step();

    // Reset in the middle of STROBE
    issue(1'b0, 2'd1, 26'h012_3456, 2'b11, 16'h0000);
    step(); step(); step(); step();
    chk("t7_in_strobe", {31'd0, abus_read}, 32'd0);
    reset = 1'b1;
    step();
    chk("t7_cs",    {29'd0, abus_chipselect}, 32'h7);
    chk("t7_rd",    {31'd0, abus_read}, 32'd1);
    chk("t7_oe",    {31'd0, abus_ad_oe}, 32'd0);
    chk("t7_rsp",   {31'd0, rsp_valid}, 32'd0);
    chk("t7_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    step();
    chk("t7_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("t7_no_rsp",      {31'd0, rsp_valid}, 32'd0);

    // Interrupt synchronizer lag
    abus_interrupt = 1'b1;
    step();
    chk("irq_lag1", {31'd0, irq}, 32'd0);
    step();
    chk("irq_lag2", {31'd0, irq}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
